hiss_tx_serializer: RTL and testbench
=====================================

HISS_TX_SERIALIZER -- requirements
Module: hiss_tx_serializer

Interface
REQ-001 Parameter DATA_W, default 12, bits per I and per Q sample.
REQ-002 Parameter HALF_DIV, default 2, pclk cycles per hiss_clk half-period; one bit period = 2*HALF_DIV pclk cycles.
REQ-003 pclk  input  1  single clock; all logic on rising edge.
REQ-004 n_p_reset  input  1  asynchronous active-low reset.
REQ-005 enable  input  1  link enable; 0 = disabled, lines and pad enables driven low.
REQ-006 sample_i  input  DATA_W  I sample to transmit.
REQ-007 sample_q  input  DATA_W  Q sample to transmit.
REQ-008 sample_valid  input  1  sample_i/sample_q valid.
REQ-009 sample_ready  output  1  holding buffer can accept a sample.
REQ-010 hiss_rxi  output  1  serial I line to LVDS pad driver.
REQ-011 hiss_rxq  output  1  serial Q line to LVDS pad driver.
REQ-012 hiss_clk  output  1  forwarded bit clock to LVDS pad driver.
REQ-013 hiss_rxien, hiss_rxqen, hiss_clken  output  1 each  pad driver enables.
REQ-014 busy  output  1  frame in progress (START, DATA or STOP).
REQ-015 frame_count  output  16  completed frames, wraps 0xFFFF -> 0x0000.

Function
REQ-016 All outputs shall be registered.
REQ-017 FSM states: DISABLED, IDLE, START, DATA, STOP.
REQ-018 Bit timer shall count 0..2*HALF_DIV-1 while enable=1 and wrap; timer wrap = bit boundary.
REQ-019 hiss_clk shall be 0 for timer 0..HALF_DIV-1 and 1 for HALF_DIV..2*HALF_DIV-1, free-running in IDLE and frame states; receiver samples on rising hiss_clk (mid-bit).
REQ-020 hiss_rxien/hiss_rxqen/hiss_clken shall equal enable delayed one pclk.
REQ-021 sample_ready = enable AND holding buffer empty; transfer on sample_valid AND sample_ready; buffer full next cycle.
REQ-022 DISABLED -> IDLE when enable=1; timer starts at 0.
REQ-023 IDLE -> START at a bit boundary when buffer full; buffer moves into I/Q shift registers and empties on that boundary.
REQ-024 Frame per line: START bit = 1, DATA_W data bits MSB first, STOP bit = 0; total DATA_W+2 bit periods.
REQ-025 START -> DATA, DATA -> STOP after DATA_W bits, each on bit boundaries.
REQ-026 At end of STOP: frame_count increments; next state START if buffer full (back-to-back, no gap), else IDLE.
REQ-027 A new sample may be accepted while a frame is in progress (buffer refill during frame).
REQ-028 hiss_rxi/hiss_rxq shall be 0 in IDLE and DISABLED and change only at bit boundaries.
REQ-029 Simultaneous buffer load (handshake) and buffer drain (START entry) in one cycle: incoming sample stored, buffer stays full.
REQ-030 enable=0 in any state: next cycle DISABLED, frame aborted, buffer flushed, timer cleared, lines and hiss_clk 0, frame_count held (aborted frame not counted).
REQ-031 Accept-to-first-START-bit latency: 1 cycle plus wait to next bit boundary (max 2*HALF_DIV cycles).

Reset
REQ-032 On n_p_reset low: state DISABLED; hiss_rxi, hiss_rxq, hiss_clk, all pad enables, sample_ready, busy = 0; frame_count = 0x0000; buffer empty; timer 0.
REQ-033 Reset deassertion shall take effect on the next pclk edge with no glitch on hiss_clk.

Verification
REQ-034 Defaults; enable=1, sample_i=0xA5C, sample_q=0x3F0 -> hiss_rxi bits 1,101001011100,0 and hiss_rxq 1,001111110000,0, 4 pclk per bit, 56 cycles, frame_count=1.
REQ-035 Two samples offered back-to-back -> second START bit immediately follows first STOP bit, no idle bit; frame_count=2.
REQ-036 Hold sample_valid=1 during frame -> sample_ready drops after one accept; reasserts at next START entry.
REQ-037 Drop enable at DATA bit 5 -> next cycle lines/hiss_clk/enables 0, busy=0, frame_count unchanged; re-enable + new sample -> clean full frame.
REQ-038 Assert n_p_reset mid-frame -> all outputs 0 immediately, frame_count=0x0000.
REQ-039 Preload frame_count=0xFFFF via 65535 frames (or force) -> next completed frame gives 0x0000.

Source files
------------

// File: rtl/hiss_tx_serializer.sv
// HISS transmit serializer: one-sample holding buffer feeding parallel I/Q
// frames (START=1, DATA_W bits MSB first, STOP=0) with a forwarded bit clock.
module hiss_tx_serializer #(
  parameter int DATA_W   = 12,
  parameter int HALF_DIV = 2
) (
  input  logic              pclk,
  input  logic              n_p_reset,
  input  logic              enable,
  input  logic [DATA_W-1:0] sample_i,
  input  logic [DATA_W-1:0] sample_q,
  input  logic              sample_valid,
  output logic              sample_ready,
  output logic              hiss_rxi,
  output logic              hiss_rxq,
  output logic              hiss_clk,
  output logic              hiss_rxien,
  output logic              hiss_rxqen,
  output logic              hiss_clken,
  output logic              busy,
  output logic [15:0]       frame_count
);

  localparam int TW = (2 * HALF_DIV > 1) ? $clog2(2 * HALF_DIV) : 1;
  localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(2 * HALF_DIV - 1);
  localparam logic [TW-1:0] T_HALF = TW'(HALF_DIV);
  localparam logic [CW-1:0] B_LAST = CW'(DATA_W - 1);

  typedef enum logic [2:0] {S_DISABLED, S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t            r_state, w_state_nxt;
  logic [TW-1:0]     r_timer, w_timer_nxt;
  logic [CW-1:0]     r_bitcnt, w_bitcnt_nxt;
  logic              r_buf_full, w_buf_full_nxt;
  logic [DATA_W-1:0] r_buf_i, r_buf_q, w_buf_i_nxt, w_buf_q_nxt;
  logic [DATA_W-1:0] r_sh_i, r_sh_q, w_sh_i_nxt, w_sh_q_nxt;
  logic              r_rxi, r_rxq, w_rxi_nxt, w_rxq_nxt;
  logic              r_clk, r_en_d, r_ready, r_busy;
  logic [15:0]       r_frame_count, w_count_nxt;
  logic              w_load, w_wrap, w_start;

  always_comb begin
    w_state_nxt    = r_state;
    w_timer_nxt    = r_timer;
    w_bitcnt_nxt   = r_bitcnt;
    w_buf_full_nxt = r_buf_full;
    w_buf_i_nxt    = r_buf_i;
    w_buf_q_nxt    = r_buf_q;
    w_sh_i_nxt     = r_sh_i;
    w_sh_q_nxt     = r_sh_q;
    w_rxi_nxt      = r_rxi;
    w_rxq_nxt      = r_rxq;
    w_count_nxt    = r_frame_count;
    w_start        = 1'b0;
    w_load         = sample_valid & r_ready;
    w_wrap         = (r_timer == T_LAST);

    if (!enable) begin
      w_state_nxt    = S_DISABLED;
      w_timer_nxt    = '0;
      w_buf_full_nxt = 1'b0;
      w_rxi_nxt      = 1'b0;
      w_rxq_nxt      = 1'b0;
    end else begin
      if (w_load) begin
        w_buf_full_nxt = 1'b1;
        w_buf_i_nxt    = sample_i;
        w_buf_q_nxt    = sample_q;
      end
      if (r_state == S_DISABLED) begin
        w_state_nxt = S_IDLE;
        w_timer_nxt = '0;
      end else begin
        w_timer_nxt = w_wrap ? '0 : r_timer + 1'b1;
        if (w_wrap) begin
          case (r_state)
            S_IDLE:  w_start = r_buf_full;
            S_START: begin
              w_state_nxt  = S_DATA;
              w_rxi_nxt    = r_sh_i[DATA_W-1];
              w_rxq_nxt    = r_sh_q[DATA_W-1];
              w_sh_i_nxt   = r_sh_i << 1;
              w_sh_q_nxt   = r_sh_q << 1;
              w_bitcnt_nxt = '0;
            end
            S_DATA: begin
              if (r_bitcnt == B_LAST) begin
                w_state_nxt = S_STOP;
                w_rxi_nxt   = 1'b0;
                w_rxq_nxt   = 1'b0;
              end else begin
                w_rxi_nxt    = r_sh_i[DATA_W-1];
                w_rxq_nxt    = r_sh_q[DATA_W-1];
                w_sh_i_nxt   = r_sh_i << 1;
                w_sh_q_nxt   = r_sh_q << 1;
                w_bitcnt_nxt = r_bitcnt + 1'b1;
              end
            end
            S_STOP: begin
              w_count_nxt = r_frame_count + 16'd1;
              w_state_nxt = S_IDLE;
              w_rxi_nxt   = 1'b0;
              w_rxq_nxt   = 1'b0;
              w_start     = r_buf_full;
            end
            default: ;
          endcase
          // Drain the buffer into the shifters; a same-cycle load keeps it full.
          if (w_start) begin
            w_state_nxt = S_START;
            w_sh_i_nxt  = r_buf_i;
            w_sh_q_nxt  = r_buf_q;
            w_rxi_nxt   = 1'b1;
            w_rxq_nxt   = 1'b1;
            if (!w_load) w_buf_full_nxt = 1'b0;
          end
        end
      end
    end
  end

  always_ff @(posedge pclk or negedge n_p_reset) begin
    if (!n_p_reset) begin
      r_state       <= S_DISABLED;
      r_timer       <= '0;
      r_bitcnt      <= '0;
      r_buf_full    <= 1'b0;
      r_buf_i       <= '0;
      r_buf_q       <= '0;
      r_sh_i        <= '0;
      r_sh_q        <= '0;
      r_rxi         <= 1'b0;
      r_rxq         <= 1'b0;
      r_clk         <= 1'b0;
      r_en_d        <= 1'b0;
      r_ready       <= 1'b0;
      r_busy        <= 1'b0;
      r_frame_count <= 16'h0000;
    end else begin
      r_state       <= w_state_nxt;
      r_timer       <= w_timer_nxt;
      r_bitcnt      <= w_bitcnt_nxt;
      r_buf_full    <= w_buf_full_nxt;
      r_buf_i       <= w_buf_i_nxt;
      r_buf_q       <= w_buf_q_nxt;
      r_sh_i        <= w_sh_i_nxt;
      r_sh_q        <= w_sh_q_nxt;
      r_rxi         <= w_rxi_nxt;
      r_rxq         <= w_rxq_nxt;
      r_clk         <= (w_state_nxt != S_DISABLED) && (w_timer_nxt >= T_HALF);
      r_en_d        <= enable;
      r_ready       <= enable & ~w_buf_full_nxt;
      r_busy        <= (w_state_nxt == S_START) || (w_state_nxt == S_DATA) ||
                       (w_state_nxt == S_STOP);
      r_frame_count <= w_count_nxt;
    end
  end

  assign sample_ready = r_ready;
  assign hiss_rxi     = r_rxi;
  assign hiss_rxq     = r_rxq;
  assign hiss_clk     = r_clk;
  assign hiss_rxien   = r_en_d;
  assign hiss_rxqen   = r_en_d;
  assign hiss_clken   = r_en_d;
  assign busy         = r_busy;
  assign frame_count  = r_frame_count;

endmodule

// File: tb/tb_hiss_tx_serializer.sv
// Directed bench for hiss_tx_serializer at default parameters (12-bit samples,
// 4 pclk per bit); frames are captured bit by bit and compared to literals.
module tb_hiss_tx_serializer;

  logic        pclk = 1'b0;
  logic        n_p_reset = 1'b0;
  logic        enable = 1'b0;
  logic [11:0] sample_i = '0;
  logic [11:0] sample_q = '0;
  logic        sample_valid = 1'b0;
  logic        sample_ready, hiss_rxi, hiss_rxq, hiss_clk;
  logic        hiss_rxien, hiss_rxqen, hiss_clken, busy;
  logic [15:0] frame_count;

  hiss_tx_serializer #(.DATA_W(12), .HALF_DIV(2)) dut (
    .pclk(pclk), .n_p_reset(n_p_reset), .enable(enable),
    .sample_i(sample_i), .sample_q(sample_q), .sample_valid(sample_valid),
    .sample_ready(sample_ready), .hiss_rxi(hiss_rxi), .hiss_rxq(hiss_rxq),
    .hiss_clk(hiss_clk), .hiss_rxien(hiss_rxien), .hiss_rxqen(hiss_rxqen),
    .hiss_clken(hiss_clken), .busy(busy), .frame_count(frame_count)
  );

  always #5 pclk = ~pclk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int acc_cyc = 0;
  always @(posedge pclk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Sample feeder: offers queued samples only while ready, or holds valid high.
  logic [23:0] fq[$];
  logic        hold_mode = 1'b0;
  logic [11:0] hold_i = 12'h123;
  logic [11:0] hold_q = 12'h456;

  initial forever begin
    @(negedge pclk);
    if (hold_mode) begin
      sample_valid = 1'b1;
      sample_i     = hold_i;
      sample_q     = hold_q;
    end else if (fq.size() > 0 && sample_ready) begin
      {sample_i, sample_q} = fq.pop_front();
      sample_valid = 1'b1;
      acc_cyc      = cyc;
    end else begin
      sample_valid = 1'b0;
    end
  end

  task automatic wait_busy(input string tag, input int lim);
    int n = 0;
    while (!busy && n < lim) begin
      @(negedge pclk);
      n++;
    end
    chk(tag, 32'(busy), 32'd1);
  endtask

  // Called at the first negedge of a START bit; returns 56 cycles later.
  task automatic run_frame(input string tag, input logic [13:0] exp_i, input logic [13:0] exp_q);
    logic [13:0] wi = '0;
    logic [13:0] wq = '0;
    logic        ci = 1'b0;
    logic        cq = 1'b0;
    int          unst = 0;
    int          clkerr = 0;
    for (int b = 0; b < 14; b++) begin
      for (int c = 0; c < 4; c++) begin
        if (c == 0) begin
          ci = hiss_rxi;
          cq = hiss_rxq;
          wi = {wi[12:0], ci};
          wq = {wq[12:0], cq};
        end else if (hiss_rxi !== ci || hiss_rxq !== cq) begin
          unst++;
        end
        if (hiss_clk !== ((c >= 2) ? 1'b1 : 1'b0)) clkerr++;
        @(negedge pclk);
      end
    end
    chk({tag, ".rxi"}, 32'(wi), 32'(exp_i));
    chk({tag, ".rxq"}, 32'(wq), 32'(exp_q));
    chk({tag, ".midbit_change"}, 32'(unst), 32'd0);
    chk({tag, ".clk_shape"}, 32'(clkerr), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int lat;
    repeat (3) @(negedge pclk);
    chk("rst_outs", 32'({sample_ready, hiss_rxi, hiss_rxq, hiss_clk, hiss_rxien,
                         hiss_rxqen, hiss_clken, busy}), 32'd0);
    chk("rst_fc", 32'(frame_count), 32'd0);

    n_p_reset = 1'b1;
    enable    = 1'b1;
    @(negedge pclk);
    chk("en_pads", 32'({hiss_rxien, hiss_rxqen, hiss_clken}), 32'b111);
    chk("en_ready", 32'(sample_ready), 32'd1);
    repeat (3) @(negedge pclk);
    chk("idle_lines", 32'({hiss_rxi, hiss_rxq, busy}), 32'd0);

    // Basic frame
    fq.push_back({12'hA5C, 12'h3F0});
    wait_busy("t1_start", 20);
    lat = cyc - acc_cyc;
    chk("t1_latency", 32'((lat >= 2 && lat <= 5) ? 1 : 0), 32'd1);
    run_frame("t1", 14'b11010010111000, 14'b10011111100000);
    chk("t1_fc", 32'(frame_count), 32'd1);
    chk("t1_idle", 32'({busy, hiss_rxi, hiss_rxq}), 32'd0);

    // Back-to-back frames
    fq.push_back({12'h5A3, 12'hC0F});
    fq.push_back({12'hFFF, 12'h000});
    wait_busy("t2_start", 20);
    run_frame("t2a", 14'b10101101000110, 14'b11100000011110);
    chk("t2_no_gap", 32'(busy), 32'd1);
    run_frame("t2b", 14'b11111111111110, 14'b10000000000000);
    chk("t2_fc", 32'(frame_count), 32'd3);
    chk("t2_idle", 32'(busy), 32'd0);

    // Valid held high across a frame
    hold_mode = 1'b1;
    n = 0;
    while (sample_ready && n < 10) begin @(negedge pclk); n++; end
    chk("t3_ready_after_accept", 32'(sample_ready), 32'd0);
    wait_busy("t3_start", 20);
    chk("t3_ready_at_start", 32'(sample_ready), 32'd1);
    @(negedge pclk);
    chk("t3_ready_refilled", 32'(sample_ready), 32'd0);
    hold_mode = 1'b0;
    n = 0;
    while (!(busy == 1'b0 && frame_count == 16'd5) && n < 200) begin @(negedge pclk); n++; end
    chk("t3_fc", 32'(frame_count), 32'd5);

    // Abort in DATA bit 5
    fq.push_back({12'hFFF, 12'hFFF});
    wait_busy("t4_start", 20);
    repeat (25) @(negedge pclk);
    chk("t4_pre_abort", 32'({busy, hiss_rxi, hiss_rxq}), 32'b111);
    enable = 1'b0;
    @(negedge pclk);
    chk("t4_abort_outs", 32'({hiss_rxi, hiss_rxq, hiss_clk, hiss_rxien, hiss_rxqen,
                              hiss_clken, busy, sample_ready}), 32'd0);
    chk("t4_abort_fc", 32'(frame_count), 32'd5);
    repeat (3) @(negedge pclk);
    chk("t4_disabled_clk", 32'(hiss_clk), 32'd0);
    enable = 1'b1;
    fq.push_back({12'h801, 12'h7FE});
    wait_busy("t4_restart", 20);
    run_frame("t4_re", 14'b11000000000010, 14'b10111111111100);
    chk("t4_fc", 32'(frame_count), 32'd6);

    // Asynchronous reset mid-frame
    fq.push_back({12'hF0F, 12'hF0F});
    wait_busy("t5_start", 20);
    repeat (10) @(negedge pclk);
    chk("t5_pre_reset", 32'({busy, hiss_rxi}), 32'b11);
    n_p_reset = 1'b0;
    #1;
    chk("t5_reset_outs", 32'({sample_ready, hiss_rxi, hiss_rxq, hiss_clk, hiss_rxien,
                              hiss_rxqen, hiss_clken, busy}), 32'd0);
    chk("t5_reset_fc", 32'(frame_count), 32'd0);
    @(negedge pclk);
    n_p_reset = 1'b1;
    @(negedge pclk);
    chk("t5_release", 32'({hiss_clk, hiss_rxien, sample_ready}), 32'b011);

    // frame_count wrap
    repeat (4) @(negedge pclk);
    force dut.r_frame_count = 16'hFFFF;
    @(negedge pclk);
    release dut.r_frame_count;
    @(negedge pclk);
    chk("t6_preload", 32'(frame_count), 32'hFFFF);
    fq.push_back({12'h000, 12'hFFF});
    wait_busy("t6_start", 20);
    run_frame("t6", 14'b10000000000000, 14'b11111111111110);
    chk("t6_wrap", 32'(frame_count), 32'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
